// File: rtl/mux_stim_pkg.sv
// Shared types and helpers for the mux stimulus sequencer.
package mux_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd7;

    function automatic logic [2:0] bin2gray3(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/mux_stim_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps to 0 after the terminal count.
module mux_stim_dwell_cnt
    import mux_stim_pkg::*;
#(
    parameter int DWELL = 10,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_stim_sequencer.sv
// Sweeps all eight {I0, I1, sel} combinations for the 2:1 mux, holding each for DWELL cycles.
// Handshake: start is taken only in IDLE/DONE; busy is high for the whole sweep; done is a level until the next start or abort.
module mux_stim_sequencer
    import mux_stim_pkg::*;
#(
    parameter int DWELL = 10,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    input  logic       loop_en,
    input  logic       gray_mode,
    output logic       I0,
    output logic       I1,
    output logic       sel,
    output logic [2:0] step,
    output logic       vld,
    output logic       wrap,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0] state;
    logic [2:0] step_q;
    logic [2:0] pat_q;
    logic       gray_q;
    logic       tc;
    logic       cnt_clr;

    function automatic logic [2:0] pattern(input logic [2:0] k, input logic g);
        return g ? bin2gray3(k) : k;
    endfunction

    // Counter idles at zero outside RUN so every sweep starts with a full dwell.
    assign cnt_clr = abort || (state != S_RUN);

    mux_stim_dwell_cnt #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~hold),
        .clr   (cnt_clr),
        .tc    (tc)
    );

    assign {I0, I1, sel} = pat_q;
    assign step          = step_q;
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            step_q <= '0;
            pat_q  <= '0;
            gray_q <= 1'b0;
            vld    <= 1'b0;
            wrap   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            vld  <= 1'b0;
            wrap <= 1'b0;
            if (abort) begin
                state  <= S_IDLE;
                step_q <= '0;
                pat_q  <= '0;
                busy   <= 1'b0;
                done   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state  <= S_RUN;
                            step_q <= '0;
                            pat_q  <= pattern(3'd0, gray_mode);
                            gray_q <= gray_mode;
                            vld    <= 1'b1;
                            busy   <= 1'b1;
                            done   <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (!hold && tc) begin
                            if (step_q != LAST_STEP) begin
                                step_q <= step_q + 3'd1;
                                pat_q  <= pattern(step_q + 3'd1, gray_q);
                                vld    <= 1'b1;
                            end else if (loop_en) begin
                                step_q <= '0;
                                pat_q  <= pattern(3'd0, gray_q);
                                vld    <= 1'b1;
                                wrap   <= 1'b1;
                            end else begin
                                // Outputs keep the last combination while parked in DONE.
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// Bench for mux_stim_sequencer: three instances (DWELL = 4, 1, 2) share one stimulus stream.
module tb_mux_stim_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic hold = 1'b0;
    logic loop_en = 1'b0;
    logic gray_mode = 1'b0;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic       d_i0 [3];
    logic       d_i1 [3];
    logic       d_sel [3];
    logic       d_vld [3];
    logic       d_wrap [3];
    logic       d_busy [3];
    logic       d_done [3];
    logic [2:0] d_step [3];
    logic [1:0] d_state [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mux_stim_sequencer #(
            .DWELL ((g == 0) ? 4 : ((g == 1) ? 1 : 2)),
            .CNT_W (16)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .abort     (abort),
            .hold      (hold),
            .loop_en   (loop_en),
            .gray_mode (gray_mode),
            .I0        (d_i0[g]),
            .I1        (d_i1[g]),
            .sel       (d_sel[g]),
            .step      (d_step[g]),
            .vld       (d_vld[g]),
            .wrap      (d_wrap[g]),
            .busy      (d_busy[g]),
            .done      (d_done[g]),
            .state_dbg (d_state[g])
        );
    end

    function automatic int dw(int i);
        case (i)
            0: return 4;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    // Model: phase 0=idle 1=run 2=done; t counts un-held RUN cycles since the sweep (or lap) began.
    int   m_phase [3] = '{0, 0, 0};
    int   m_t     [3] = '{0, 0, 0};
    logic m_gray  [3] = '{1'b0, 1'b0, 1'b0};
    logic m_vld   [3] = '{1'b0, 1'b0, 1'b0};
    logic m_wrap  [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            m_phase[i] = 0;
            m_t[i]     = 0;
            m_gray[i]  = 1'b0;
            m_vld[i]   = 1'b0;
            m_wrap[i]  = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (abort) begin
                    m_phase[i] = 0;
                    m_t[i]     = 0;
                    m_vld[i]   = 1'b0;
                    m_wrap[i]  = 1'b0;
                end else if (m_phase[i] != 1 && start) begin
                    m_phase[i] = 1;
                    m_t[i]     = 0;
                    m_gray[i]  = gray_mode;
                    m_vld[i]   = 1'b1;
                    m_wrap[i]  = 1'b0;
                end else if (m_phase[i] == 1 && !hold) begin
                    m_t[i]    = m_t[i] + 1;
                    m_wrap[i] = 1'b0;
                    if (m_t[i] == 8 * dw(i)) begin
                        if (loop_en) begin
                            m_t[i]    = 0;
                            m_vld[i]  = 1'b1;
                            m_wrap[i] = 1'b1;
                        end else begin
                            m_phase[i] = 2;
                            m_vld[i]   = 1'b0;
                        end
                    end else begin
                        m_vld[i] = ((m_t[i] % dw(i)) == 0);
                    end
                end else begin
                    m_vld[i]  = 1'b0;
                    m_wrap[i] = 1'b0;
                end
            end
        end
    end

    function automatic logic [11:0] model_vec(int i);
        int         k;
        logic [2:0] k3;
        logic [2:0] p;
        case (m_phase[i])
            1:       k = m_t[i] / dw(i);
            2:       k = 7;
            default: k = 0;
        endcase
        k3 = 3'(k);
        p  = m_gray[i] ? (k3 ^ (k3 >> 1)) : k3;
        return {p, k3, m_vld[i], m_wrap[i], (m_phase[i] == 1), (m_phase[i] == 2), 2'(m_phase[i])};
    endfunction

    function automatic logic [11:0] dut_vec(int i);
        return {d_i0[i], d_i1[i], d_sel[i], d_step[i], d_vld[i], d_wrap[i],
                d_busy[i], d_done[i], d_state[i]};
    endfunction

    function automatic logic [2:0] pat(int i);
        return {d_i0[i], d_i1[i], d_sel[i]};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (dut_vec(i) !== model_vec(i)) begin
                n_fail++;
                $display("FAIL cycle_cmp dut%0d t=%0t got=%b exp=%b", i, $time, dut_vec(i), model_vec(i));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic go(input logic g, input logic l);
        @(negedge clk);
        gray_mode = g;
        loop_en   = l;
        start     = 1'b1;
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while ((d_busy[0] || d_busy[1] || d_busy[2]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("quiet_timeout", 32'(k < 200), 32'd1);
    endtask

    logic [2:0] gexp [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    initial begin
        int vcount;
        int done_at;
        int cnt011;

        // Reset values
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_pat", 32'(pat(i)), 32'd0);
            check("reset_flags", 32'({d_vld[i], d_wrap[i], d_busy[i], d_done[i]}), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Binary sweep, DWELL=4
        go(1'b0, 1'b0);
        vcount  = 0;
        done_at = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (d_vld[0]) begin
                if (vcount < 8) begin
                    check("s1_vld_pos", 32'(n), 32'(1 + 4 * vcount));
                    check("s1_vld_pat", 32'(pat(0)), 32'(vcount));
                end
                vcount++;
            end
            if (d_done[0] && done_at == 0) done_at = n;
        end
        check("s1_vld_count", 32'(vcount), 32'd8);
        check("s1_done_cycle", 32'(done_at), 32'd33);
        check("s1_hold_111", 32'(pat(0)), 32'd7);
        wait_quiet();

        // Gray sweep, DWELL=1, restarted from DONE
        go(1'b1, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n <= 8) begin
                check("s2_vld", 32'(d_vld[1]), 32'd1);
                check("s2_gray_pat", 32'(pat(1)), 32'(gexp[n-1]));
            end
            if (n == 9) begin
                check("s2_done", 32'(d_done[1]), 32'd1);
                check("s2_vld_end", 32'(d_vld[1]), 32'd0);
            end
        end
        wait_quiet();

        // Looping, DWELL=2
        go(1'b0, 1'b1);
        done_at = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 16) check("s3_pre_wrap", 32'({d_wrap[2], d_step[2]}), 32'd7);
            if (n == 17) check("s3_wrap", 32'({d_wrap[2], d_busy[2], d_step[2]}), 32'b11000);
            if (n == 18) begin
                check("s3_wrap_clear", 32'({d_wrap[2], d_busy[2]}), 32'b01);
                loop_en = 1'b0;
            end
            if (d_done[2] && done_at == 0) done_at = n;
        end
        check("s3_done_cycle", 32'(done_at), 32'd33);
        wait_quiet();

        // Hold in the middle of step 3, DWELL=4
        go(1'b0, 1'b0);
        cnt011 = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 14) hold = 1'b1;
            if (n == 19) hold = 1'b0;
            if (pat(0) == 3'b011) cnt011++;
            if (n >= 14 && n <= 21) check("s4_no_vld", 32'(d_vld[0]), 32'd0);
            if (n == 22) check("s4_step4", 32'({d_vld[0], pat(0)}), 32'b1100);
        end
        check("s4_dwell_011", 32'(cnt011), 32'd9);
        wait_quiet();

        // Ignored start in RUN, then abort together with start at step 5
        go(1'b0, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 6) start = 1'b1;
            if (n == 7) start = 1'b0;
            if (n == 8) check("s5_no_restart", 32'(d_step[0]), 32'd1);
            if (n == 22) begin
                check("s5_at_step5", 32'(d_step[0]), 32'd5);
                abort = 1'b1;
                start = 1'b1;
            end
            if (n == 23) begin
                check("s5_abort_out", 32'({pat(0), d_step[0], d_busy[0], d_done[0]}), 32'd0);
                check("s5_abort_state", 32'(d_state[0]), 32'd0);
                abort = 1'b0;
                start = 1'b0;
            end
            if (n == 28) check("s5_stay_idle", 32'({pat(0), d_busy[0]}), 32'd0);
        end

        // Asynchronous reset mid-dwell at step 6
        go(1'b0, 1'b0);
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        check("s6_at_step6", 32'(d_step[0]), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("s6_async_pat", 32'({pat(i), d_step[i]}), 32'd0);
            check("s6_async_flags", 32'({d_vld[i], d_wrap[i], d_busy[i], d_done[i]}), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("s6_idle_after", 32'({pat(0), d_state[0], d_busy[0]}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_stim_sequencer.md
Name: mux_stim_sequencer

Overview:
- Upstream stimulus stage for the 2:1 mux block `ifelse`.
- Sweeps all 8 combinations of {I0, I1, sel}.
- Holds each combination for a programmable dwell time, then steps to the next.
- Outputs connect directly to the mux's I0, I1 and sel inputs. Start/busy/done handshake, with single-run or continuous loop and binary or Gray sweep order.

Parameters:
- DWELL, default 10, clock cycles each combination is held; legal range 1..65535.
- CNT_W, default 16, dwell counter width; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; honoured in IDLE or DONE only.
- abort  in  1  synchronous abort to IDLE; highest priority after reset.
- hold  in  1  freeze dwell counter and outputs while in RUN.
- loop_en  in  1  1 = wrap from step 7 to step 0 instead of finishing; sampled live at the wrap point.
- gray_mode  in  1  1 = Gray-code sweep order; sampled on the start cycle only.
- I0  out  1  mux data input 0.
- I1  out  1  mux data input 1.
- sel  out  1  mux select.
- step  out  3  current step index k.
- vld  out  1  one-cycle pulse on every new combination.
- wrap  out  1  one-cycle pulse on a 7→0 wrap.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - I0=I1=sel=0, step=0, vld=0, wrap=0, busy=0, done=0.
  - Dwell counter = 0, latched gray flag = 0.
  - Takes effect immediately, including mid-sweep.
- Pattern mapping, from step k:
  - p = k in binary mode; p = k ^ (k>>1) in Gray mode.
  - {I0, I1, sel} = {p[2], p[1], p[0]}, all registered outputs.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 (and abort=0):
  - Next edge: RUN, step=0, pattern(0) on the outputs, vld=1, busy=1, done=0, cnt=0.
  - gray_mode is latched on this edge.
- RUN, hold=0:
  - cnt increments every cycle.
  - When cnt==DWELL-1 and step<7: step+1, new pattern, vld=1, cnt=0.
  - Each combination is therefore visible for exactly DWELL cycles.
- RUN, terminal point (cnt==DWELL-1, step==7):
  - loop_en=1: step=0, pattern(0), vld=1, wrap=1, cnt=0; stay in RUN.
  - loop_en=0: go to DONE, busy=0, done=1; outputs keep pattern(7); no vld.
- RUN, hold=1: cnt, step and outputs frozen; vld=0. The sweep resumes exactly where it stopped, with the remaining dwell preserved.
- abort=1 in any state:
  - Next edge: IDLE, outputs 0, step=0, busy=0, done=0, vld=0, wrap=0.
  - Overrides start and hold asserted in the same cycle.
- start while in RUN: ignored; no restart.
- done is a level held until the next start or abort.
- start in DONE restarts a sweep in the same way as from IDLE.
- DWELL=1: a new combination every cycle; vld stays high continuously during RUN.

Decomposition:
- Shared package mux_stim_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant LAST_STEP=3'd7.
  - Function bin2gray3.
- One sub-module, mux_stim_dwell_cnt: a dwell counter with enable (~hold), clear, and a terminal-count output. The FSM and pattern mapping stay in the top level.

Test Plan:
- Reset, then start (DWELL=4, binary, loop_en=0):
  - {I0,I1,sel} sequence 000,001,010,011,100,101,110,111, each for 4 cycles.
  - 8 vld pulses spaced 4 cycles apart.
  - done=1 at cycle 33 after start; outputs hold 111.
- gray_mode=1, DWELL=1:
  - Steps 0..7 yield 000,001,011,010,110,111,101,100 on consecutive cycles.
  - vld stays high for 8 cycles, then done=1.
- loop_en=1, DWELL=2:
  - After step 7, step returns to 0 with wrap=1 for exactly one cycle; busy stays 1.
  - Drop loop_en; the next terminal point gives done=1.
- hold=1 for 5 cycles in the middle of step 3 (cnt=1, DWELL=4):
  - Outputs stay 011 for 4+5 cycles in total; no vld during hold.
  - Step 4 follows afterwards.
- abort asserted together with start at step 5:
  - Next cycle: IDLE, outputs 000, busy=0, done=0.
  - A start pulse during RUN earlier in the sweep produces no restart.
- rst_n=0 asynchronously mid-dwell at step 6:
  - All outputs are 0 before the next clock edge.
  - After release, nothing changes until start.
